// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the BCD calculator controller: key-code constants,
// operator encoding (as shown on disp_op), FSM state enumeration, and a helper
// that counts the significant digits of a packed BCD value.
// -----------------------------------------------------------------------------
package calc_pkg;

    // Key codes delivered on key_code
    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] KEY_ADD       = 4'hA;
    localparam logic [3:0] KEY_SUB       = 4'hB;
    localparam logic [3:0] KEY_CLR       = 4'hC;
    localparam logic [3:0] KEY_EQU       = 4'hD;

    // Operator encoding, driven directly onto disp_op
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        S_A    = 3'd0,   // entering operand A
        S_B    = 3'd1,   // entering operand B
        S_CALC = 3'd2,   // digit-serial add/subtract
        S_NEG  = 3'd3,   // ten's complement of a negative difference
        S_RES  = 3'd4,   // result displayed
        S_ERR  = 3'd5    // add overflow displayed
    } state_e;

    // Position of the most significant non-zero digit among the low n digits
    // of v (0 for a zero value). Values are zero-extended to 8 digits.
    function automatic int unsigned sig_digits(input logic [31:0] v,
                                               input int unsigned n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n && v[4*i +: 4] != 4'd0) cnt = i + 1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// -----------------------------------------------------------------------------
// bcd_digit_alu
// Combinational single-digit BCD adder/subtractor.
//   a, b  : BCD digit operands (0-9)
//   cin   : carry in (add) or borrow in (subtract)
//   sub   : 0 = a + b + cin, 1 = a - b - cin
//   d     : BCD result digit
//   cout  : carry out (add) or borrow out (subtract)
// -----------------------------------------------------------------------------
module bcd_digit_alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        // Range is -10..9, so bit 4 is the sign of the difference.
        diff = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        if (sub) begin
            if (diff[4]) begin
                d    = 4'(diff + 5'd10);
                cout = 1'b1;
            end else begin
                d    = diff[3:0];
                cout = 1'b0;
            end
        end else begin
            if (sum > 5'd9) begin
                d    = 4'(sum - 5'd10);
                cout = 1'b1;
            end else begin
                d    = sum[3:0];
                cout = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_calc_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_calc_ctrl
// Keypad-driven BCD calculator controller: two DIGITS-digit operands, add or
// subtract, digit-serial evaluation through one bcd_digit_alu.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   0-9 digit, A add, B subtract, C clear, D equals, E/F ignored
//   key_ready  key accepted this cycle (low while busy)
//   disp_bcd   displayed value, digit 0 in [3:0]
//   disp_neg   displayed value is negative
//   disp_op    stored operator (00 none, 01 add, 10 subtract)
//   busy       computation in progress
//   done       one-cycle pulse when a result first appears
//   overflow   sticky add overflow
//
// Build option
//   CALC_CHAIN_EN  operator key on a non-negative result continues with the
//                  result as operand A.
// -----------------------------------------------------------------------------
module bcd_calc_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  key_ready,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  disp_neg,
    output logic [1:0]            disp_op,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    state_e          state_q, state_nx;
    op_e             op_q, op_nx;
    logic [W-1:0]    a_q, a_nx, b_q, b_nx, r_q, r_nx;
    logic [CW-1:0]   a_cnt_q, a_cnt_nx, b_cnt_q, b_cnt_nx;
    logic [IW-1:0]   idx_q, idx_nx;
    logic            cy_q, cy_nx;
    logic            neg_q, neg_nx;
    logic            ovf_q, ovf_nx;
    logic            done_q, done_nx;

    logic            accept;
    logic            is_digit;
    logic            is_op;
    op_e             key_op;
    int              idx_i;

    logic [3:0]      alu_a, alu_b, alu_d;
    logic            alu_sub, alu_c;

    assign busy      = (state_q == S_CALC) || (state_q == S_NEG);
    assign key_ready = !busy;
    assign accept    = key_valid && key_ready;
    assign is_digit  = (key_code <= KEY_MAX_DIGIT);
    assign is_op     = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    assign key_op    = (key_code == KEY_ADD) ? OP_ADD : OP_SUB;
    assign idx_i     = int'(idx_q);

    // The ALU adds/subtracts A and B digits in S_CALC and computes 0 - R
    // digit-wise (ten's complement) in S_NEG.
    always_comb begin
        alu_a   = a_q[4*idx_i +: 4];
        alu_b   = b_q[4*idx_i +: 4];
        alu_sub = (op_q == OP_SUB);
        if (state_q == S_NEG) begin
            alu_a   = 4'd0;
            alu_b   = r_q[4*idx_i +: 4];
            alu_sub = 1'b1;
        end
    end

    bcd_digit_alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .cin  (cy_q),
        .sub  (alu_sub),
        .d    (alu_d),
        .cout (alu_c)
    );

    // Next-state and datapath logic.
    // NOTE: every *_nx signal takes its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state_q;
        op_nx    = op_q;
        a_nx     = a_q;
        b_nx     = b_q;
        r_nx     = r_q;
        a_cnt_nx = a_cnt_q;
        b_cnt_nx = b_cnt_q;
        idx_nx   = idx_q;
        cy_nx    = cy_q;
        neg_nx   = neg_q;
        ovf_nx   = ovf_q;
        done_nx  = 1'b0;

        unique case (state_q)
            S_A: if (accept) begin
                if (is_digit) begin
                    if (a_cnt_q != CNT_FULL) begin
                        a_nx = {a_q[W-5:0], key_code};
                        // Leading zeros are not significant.
                        if (a_cnt_q != '0 || key_code != 4'd0)
                            a_cnt_nx = a_cnt_q + CW'(1);
                    end
                end else if (is_op) begin
                    op_nx    = key_op;
                    b_nx     = '0;
                    b_cnt_nx = '0;
                    state_nx = S_B;
                end
            end

            S_B: if (accept) begin
                if (is_digit) begin
                    if (b_cnt_q != CNT_FULL) begin
                        b_nx = {b_q[W-5:0], key_code};
                        if (b_cnt_q != '0 || key_code != 4'd0)
                            b_cnt_nx = b_cnt_q + CW'(1);
                    end
                end else if (is_op) begin
                    // Operator can be changed only before B is entered.
                    if (b_cnt_q == '0) op_nx = key_op;
                end else if (key_code == KEY_EQU) begin
                    idx_nx   = '0;
                    cy_nx    = 1'b0;
                    state_nx = S_CALC;
                end
            end

            S_CALC: begin
                r_nx[4*idx_i +: 4] = alu_d;
                cy_nx  = alu_c;
                idx_nx = idx_q + IW'(1);
                if (idx_q == IDX_LAST) begin
                    idx_nx = '0;
                    cy_nx  = 1'b0;
                    if (alu_c && op_q == OP_SUB) begin
                        // Difference wrapped modulo 10^DIGITS: complement it.
                        state_nx = S_NEG;
                    end else if (alu_c) begin
                        r_nx     = '0;
                        neg_nx   = 1'b0;
                        ovf_nx   = 1'b1;
                        done_nx  = 1'b1;
                        state_nx = S_ERR;
                    end else begin
                        neg_nx   = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = S_RES;
                    end
                end
            end

            S_NEG: begin
                r_nx[4*idx_i +: 4] = alu_d;
                cy_nx  = alu_c;
                idx_nx = idx_q + IW'(1);
                if (idx_q == IDX_LAST) begin
                    idx_nx   = '0;
                    cy_nx    = 1'b0;
                    neg_nx   = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = S_RES;
                end
            end

            S_RES, S_ERR: if (accept) begin
                if (is_digit) begin
                    a_nx     = W'(key_code);
                    a_cnt_nx = (key_code != 4'd0) ? CW'(1) : '0;
                    b_nx     = '0;
                    b_cnt_nx = '0;
                    r_nx     = '0;
                    op_nx    = OP_NONE;
                    neg_nx   = 1'b0;
                    ovf_nx   = 1'b0;
                    state_nx = S_A;
`ifdef CALC_CHAIN_EN
                end else if (is_op && state_q == S_RES && !neg_q) begin
                    a_nx     = r_q;
                    a_cnt_nx = CW'(sig_digits(32'(r_q), DIGITS));
                    b_nx     = '0;
                    b_cnt_nx = '0;
                    op_nx    = key_op;
                    state_nx = S_B;
`endif
                end
            end

            default: state_nx = S_A;
        endcase

        // Clear is accepted in every non-busy state.
        if (accept && key_code == KEY_CLR) begin
            a_nx     = '0;
            b_nx     = '0;
            r_nx     = '0;
            a_cnt_nx = '0;
            b_cnt_nx = '0;
            op_nx    = OP_NONE;
            neg_nx   = 1'b0;
            ovf_nx   = 1'b0;
            state_nx = S_A;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_A;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            op_q    <= op_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            r_q     <= r_nx;
            a_cnt_q <= a_cnt_nx;
            b_cnt_q <= b_cnt_nx;
            idx_q   <= idx_nx;
            cy_q    <= cy_nx;
            neg_q   <= neg_nx;
            ovf_q   <= ovf_nx;
            done_q  <= done_nx;
        end
    end

    // Display keeps showing the last entered operand while computing.
    always_comb begin
        unique case (state_q)
            S_A:                disp_bcd = a_q;
            S_B, S_CALC, S_NEG: disp_bcd = (b_cnt_q != '0) ? b_q : a_q;
            default:            disp_bcd = r_q;
        endcase
    end

    assign disp_neg = neg_q;
    assign disp_op  = op_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_calc_ctrl
// Directed, self-checking bench for bcd_calc_ctrl with DIGITS=4. Inputs change
// on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bcd_calc_ctrl;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                key_valid = 1'b0;
    logic [3:0]          key_code = 4'h0;
    logic                key_ready;
    logic [4*DIGITS-1:0] disp_bcd;
    logic                disp_neg;
    logic [1:0]          disp_op;
    logic                busy;
    logic                done;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    bcd_calc_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .disp_bcd  (disp_bcd),
        .disp_neg  (disp_neg),
        .disp_op   (disp_op),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle key strobe; returns on the falling edge after it was sampled.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Cycles from the equals key to the done pulse, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    logic seen_done;

    initial begin
        // Reset state
        #12;
        check("rst_disp",  32'(disp_bcd),  32'h0);
        check("rst_ready", 32'(key_ready), 32'h1);
        check("rst_flags", {27'd0, disp_neg, disp_op, busy, done, overflow}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 12 + 34 = 46
        press(4'h1); press(4'h2);
        check("a_entry", 32'(disp_bcd), 32'h0012);
        press(4'hA);
        check("op_shows_a", 32'(disp_bcd), 32'h0012);
        check("op_add", 32'(disp_op), 32'h1);
        press(4'h3);
        check("b_entry", 32'(disp_bcd), 32'h0003);
        press(4'h4);
        press(4'hD);
        check("calc_busy",  32'(busy),      32'h1);
        check("calc_ready", 32'(key_ready), 32'h0);
        wait_done(lat);
        check("add_latency", 32'(lat), 32'd5);
        check("add_result",  32'(disp_bcd), 32'h0046);
        check("add_neg",     32'(disp_neg), 32'h0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'h0);

        // 15 - 42 = -27
        press(4'h1); press(4'h5); press(4'hB); press(4'h4); press(4'h2);
        press(4'hD);
        wait_done(lat);
        check("sub_latency", 32'(lat), 32'd9);
        check("sub_result",  32'(disp_bcd), 32'h0027);
        check("sub_neg",     32'(disp_neg), 32'h1);
        // Operator on a negative result is ignored in every build
        press(4'hA);
        check("neg_op_ignored", {disp_op, disp_bcd}, {2'b10, 16'h0027});

        // 9999 + 1 overflows
        press(4'h9); press(4'h9); press(4'h9); press(4'h9);
        check("new_a_after_res", {disp_neg, disp_op, disp_bcd}, {1'b0, 2'b00, 16'h9999});
        press(4'hA); press(4'h1); press(4'hD);
        repeat (8) @(negedge clk);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_disp", 32'(disp_bcd), 32'h0);
        press(4'hB);
        check("err_op_ignored", 32'(overflow), 32'h1);
        press(4'hC);
        check("clr_ovf",  32'(overflow), 32'h0);
        check("clr_disp", {disp_op, disp_bcd}, 32'h0);

        // Leading zeros, digit limit, key dropped while busy
        press(4'h0); press(4'h0); press(4'h1); press(4'h2);
        press(4'h3); press(4'h4); press(4'h5);
        check("digit_limit", 32'(disp_bcd), 32'h1234);
        press(4'hA); press(4'h1); press(4'hD);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h9;
        #1;
        check("busy_not_ready", 32'(key_ready), 32'h0);
        @(negedge clk);
        key_valid = 1'b0;
        wait_done(lat);
        check("busy_key_lost", {disp_op, disp_bcd}, {2'b01, 16'h1235});

        // Equals ignored in S_A
        press(4'hC); press(4'h3); press(4'hD);
        check("eq_in_a", {busy, disp_bcd}, {1'b0, 16'h0003});

        // Operator replaced while B empty; ignored after a B digit: 6 - 2
        press(4'hC); press(4'h6); press(4'hA); press(4'hB);
        check("op_replace", 32'(disp_op), 32'h2);
        press(4'h2); press(4'hA);
        check("op_locked", 32'(disp_op), 32'h2);
        press(4'hD);
        wait_done(lat);
        check("sub_pos", {disp_neg, disp_bcd}, {1'b0, 16'h0004});

        // Chaining: 5 + 3 = 8, then + 2
        press(4'hC); press(4'h5); press(4'hA); press(4'h3); press(4'hD);
        wait_done(lat);
        check("chain_first", 32'(disp_bcd), 32'h0008);
        press(4'hA);
`ifdef CALC_CHAIN_EN
        check("chain_op", {disp_op, disp_bcd}, {2'b01, 16'h0008});
        press(4'h2);
        check("chain_b", 32'(disp_bcd), 32'h0002);
        press(4'hD);
        wait_done(lat);
        check("chain_result", 32'(disp_bcd), 32'h0010);
`else
        check("nochain_op", {disp_op, disp_bcd}, {2'b01, 16'h0008});
        press(4'h2);
        check("nochain_new_a", {disp_op, disp_bcd}, {2'b00, 16'h0002});
`endif

        // Reset two cycles into S_CALC
        press(4'hC); press(4'h1); press(4'hA); press(4'h2); press(4'hD);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_disp",  32'(disp_bcd),  32'h0);
        check("abort_ready", 32'(key_ready), 32'h1);
        check("abort_flags", {27'd0, disp_neg, disp_op, busy, done, overflow}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check("abort_no_done", 32'(seen_done), 32'h0);
        press(4'h7);
        check("after_abort", 32'(disp_bcd), 32'h0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_calc_ctrl.md
BCD_CALC_CTRL -- requirements
Module: bcd_calc_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits per operand and result (legal 2..8).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_valid  input  1  one-cycle strobe: key_code is a new, debounced key.
REQ-005 key_code  input  4  key value: 0x0-0x9 digit, 0xA add, 0xB subtract, 0xC clear, 0xD equals; 0xE/0xF ignored.
REQ-006 key_ready  output  1  high when a key_valid in this cycle is accepted.
REQ-007 disp_bcd  output  4*DIGITS  value to display, digit 0 in bits [3:0].
REQ-008 disp_neg  output  1  displayed value is negative.
REQ-009 disp_op  output  2  stored operator: 00 none, 01 add, 10 subtract.
REQ-010 busy  output  1  computation in progress.
REQ-011 done  output  1  one-cycle pulse in the first cycle a result is shown.
REQ-012 overflow  output  1  sticky result overflow, cleared by clear key or reset.

Function
REQ-013 States SHALL be S_A (enter A), S_B (enter B), S_CALC, S_NEG, S_RES, S_ERR.
REQ-014 Digit key in S_A/S_B SHALL shift the operand left one digit, inserting the key into digit 0.
REQ-015 Digit keys SHALL be ignored once the operand holds DIGITS significant digits; a 0 entered into a zero operand SHALL not count as significant.
REQ-016 Operator key in S_A SHALL store the operator, clear B, and enter S_B.
REQ-017 Operator key in S_B SHALL replace the operator when B has no digits; otherwise it SHALL be ignored.
REQ-018 Equals key SHALL be ignored in S_A; in S_B it SHALL enter S_CALC.
REQ-019 S_CALC SHALL process one digit per cycle, LSD first, for exactly DIGITS cycles, using carry (add) or borrow (subtract).
REQ-020 Add with final carry SHALL enter S_ERR: overflow=1, disp_bcd=0, disp_neg=0.
REQ-021 Subtract with final borrow SHALL enter S_NEG, which SHALL ten's-complement the result over DIGITS cycles and set disp_neg=1.
REQ-022 Equals-to-done latency SHALL be DIGITS+1 cycles (add, non-negative subtract) and 2*DIGITS+1 cycles (negative subtract).
REQ-023 busy SHALL be high exactly in S_CALC and S_NEG; key_ready SHALL be low there, and keys arriving then SHALL be dropped.
REQ-024 key_ready SHALL be high in every other state.
REQ-025 Display SHALL show A in S_A, B in S_B once B has a digit (A before), the previous value in S_CALC/S_NEG, and the result in S_RES.
REQ-026 Display outputs SHALL update one cycle after an accepted key.
REQ-027 Digit key in S_RES or S_ERR SHALL start a new A containing that digit, clear overflow and the operator, and enter S_A.
REQ-028 Clear key in any non-busy state SHALL zero A, B, the operator, disp_neg and overflow, and enter S_A.
REQ-029 Equals in S_RES and all keys except digit and clear in S_ERR SHALL be ignored.

Reset
REQ-030 Reset SHALL immediately force S_A, zero A, B, result and operator, and drive all outputs to 0 except key_ready=1.
REQ-031 Reset asserted during S_CALC/S_NEG SHALL abort the computation with no done pulse.

Configuration
REQ-032 Macro CALC_CHAIN_EN defined: an operator key in S_RES with disp_neg=0 SHALL load the result into A, store the operator, and enter S_B.
REQ-033 With disp_neg=1, that operator key SHALL be ignored.
REQ-034 Macro undefined: operator keys in S_RES SHALL be ignored.

Structure
REQ-035 Shared package calc_pkg SHALL hold the key-code constants, operator encoding and state enumeration.
REQ-036 One sub-module, bcd_digit_alu, SHALL be used: a combinational single-digit BCD add/subtract with carry/borrow in and out.

Verification (DIGITS=4)
REQ-037 Keys 1,2,A,3,4,D -> done 5 cycles after D; disp_bcd=0x0046, disp_neg=0.
REQ-038 Keys 1,5,B,4,2,D -> done 9 cycles after D; disp_bcd=0x0027, disp_neg=1.
REQ-039 Keys 9,9,9,9,A,1,D -> overflow=1, disp_bcd=0; then C -> overflow=0, disp_bcd=0.
REQ-040 Keys 0,0,1,2,3,4,5 -> disp_bcd=0x1234 (fifth digit ignored); a key during busy -> key_ready=0 and is lost.
REQ-041 Keys 5,A,3,D,A,2,D -> with CALC_CHAIN_EN disp_bcd=0x0010; without it the second A,2 leaves 0x0008, then 2 starts A=0x0002.
REQ-042 Reset pulsed 2 cycles into S_CALC -> immediate all-zero outputs, no done pulse, next key 7 shows 0x0007.
